pixel_sink: RTL

- Receiving end of the box/shape drawing pixel stream. Accepts (x, y, colour, last) pixel beats from a drawer over a valid/ready handshake and buffers them in a small FIFO.
- Converts each beat to a linear framebuffer address, clips off-screen pixels and issues single-word writes to the framebuffer port, which can apply backpressure.
- Sits between shape drawers and the framebuffer / VGA adapter memory.

---
 rtl/pixel_sink_pkg.sv | 26 ++
 rtl/pixel_sink_fifo.sv | 56 +++++
 rtl/pixel_sink.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pixel_sink_pkg.sv
// Shared definitions for the pixel stream between the shape drawers and the sink.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default screen geometry and coordinate widths, plus the pixel-beat
// struct that the drawers place on the stream.
package pixel_sink_pkg;

    localparam int DEF_X_W        = 8;
    localparam int DEF_Y_W        = 7;
    localparam int DEF_COLOUR_W   = 3;
    localparam int DEF_SCREEN_W   = 160;
    localparam int DEF_SCREEN_H   = 120;
    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int CLIP_CNT_W     = 16;

    // One pixel beat as produced by a drawer at the default geometry.
    typedef struct packed {
        logic [DEF_X_W-1:0]      x;
        logic [DEF_Y_W-1:0]      y;
        logic [DEF_COLOUR_W-1:0] colour;
        logic                    last;
    } pixel_beat_t;

endpackage

// File: rtl/pixel_sink_fifo.sv
// Synchronous FIFO for pixel beats, DEPTH entries of WIDTH bits.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full_o is derived from registered pointers only; the caller never pushes while full.
//
// Ports: clock/resetn; push_i + push_dat_i write side; pop_i + head_o read side
// (head_o is the current oldest entry, valid while !empty_o); full_o, empty_o.
module pixel_sink_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/pixel_sink.sv
// Pixel stream sink: buffers (x, y, colour, last) beats, clips off-screen pixels, writes the framebuffer.
// Latency: a beat accepted at edge N drives mem_we from edge N+1 (one FIFO stage + one output stage).
// Backpressure: mem_ready low holds the output stage; in_ready = !fifo_full, from registers only.
//
// Ports: clock, resetn (async, active low); in_valid/in_ready/in_x/in_y/in_colour/in_last
// drawer side; mem_we/mem_ready/mem_addr/mem_data framebuffer side; shape_done pulse,
// busy status, clip_count saturating off-screen drop counter.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int COLOUR_W   = DEF_COLOUR_W,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X_W-1:0]        in_x,
    input  logic [Y_W-1:0]        in_y,
    input  logic [COLOUR_W-1:0]   in_colour,
    input  logic                  in_last,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [COLOUR_W-1:0]   mem_data,
    output logic                  shape_done,
    output logic                  busy,
    output logic [CLIP_CNT_W-1:0] clip_count
);

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
        logic                last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // Limits held one bit wider than the coordinates so a screen size equal to
    // 2^W still compares correctly.
    localparam logic [X_W:0]    X_LIM      = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]    Y_LIM      = (Y_W+1)'(SCREEN_H);
    localparam logic [ADDR_W:0] ROW_STRIDE = (ADDR_W+1)'(SCREEN_W);
    localparam logic [CLIP_CNT_W-1:0] CLIP_MAX = '1;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    beat_t       in_beat;
    logic [BEAT_W-1:0] head_dat;
    beat_t       head;

    assign in_beat   = '{x: in_x, y: in_y, colour: in_colour, last: in_last};
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;

    pixel_sink_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .push_i     (fifo_push),
        .push_dat_i (in_beat),
        .pop_i      (fifo_pop),
        .head_o     (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head = beat_t'(head_dat);

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q,   mem_addr_d;
    logic [COLOUR_W-1:0]   mem_data_q,   mem_data_d;
    logic                  last_q,       last_d;
    logic                  shape_done_q, shape_done_d;
    logic [1:0]            owed_q,       owed_d;
    logic [CLIP_CNT_W-1:0] clip_cnt_q,   clip_cnt_d;

    logic             stage_free;
    logic             head_clip;
    logic [ADDR_W:0]  head_addr;
    logic             retire_wr;
    logic             retire_clip;
    logic [2:0]       retire_tally;

    assign stage_free = !mem_we_q || mem_ready;
    assign fifo_pop   = stage_free && !fifo_empty;

    assign head_clip = ({1'b0, head.x} >= X_LIM) || ({1'b0, head.y} >= Y_LIM);
    assign head_addr = (ADDR_W+1)'(head.y) * ROW_STRIDE + (ADDR_W+1)'(head.x);

    // A shape ends either when its final write is accepted or when its final
    // beat is clipped away at the pop.
    assign retire_wr   = mem_we_q && mem_ready && last_q;
    assign retire_clip = fifo_pop && head_clip && head.last;

    // Both kinds of retirement can land on one edge (a write draining while a
    // clipped last beat pops); the second pulse is carried over so every
    // shape still gets its own shape_done cycle.
    assign retire_tally = {1'b0, owed_q} + {2'b00, retire_wr} + {2'b00, retire_clip};

    always_comb begin
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        last_d       = last_q;
        clip_cnt_d   = clip_cnt_q;
        shape_done_d = (retire_tally != 3'd0);
        owed_d       = shape_done_d ? 2'(retire_tally - 3'd1) : 2'd0;

        if (stage_free) begin
            mem_we_d = 1'b0;
        end

        if (fifo_pop) begin
            if (head_clip) begin
                if (clip_cnt_q != CLIP_MAX) begin
                    clip_cnt_d = clip_cnt_q + 1'b1;
                end
            end else begin
                mem_we_d   = 1'b1;
                mem_addr_d = ADDR_W'(head_addr);
                mem_data_d = head.colour;
                last_d     = head.last;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            last_q       <= 1'b0;
            shape_done_q <= 1'b0;
            owed_q       <= 2'd0;
            clip_cnt_q   <= '0;
        end else begin
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            last_q       <= last_d;
            shape_done_q <= shape_done_d;
            owed_q       <= owed_d;
            clip_cnt_q   <= clip_cnt_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign shape_done = shape_done_q;
    assign busy       = !fifo_empty || mem_we_q;
    assign clip_count = clip_cnt_q;

endmodule
